sha512_msg_padder: RTL
======================

SHA512_MSG_PADDER -- requirements
Module: sha512_msg_padder

Interface
REQ-001 Parameter: LEN_W, 64, width of the message bit-length counter; legal values 64..128; bits above LEN_W in the 128-bit length field are zero.
REQ-002 clk  in  1  single clock; all state on posedge clk.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 zeroize  in  1  synchronous clear of all state and buffer contents.
REQ-005 s_valid / s_ready  in / out  1 / 1  message-word handshake; a transfer occurs when both are 1 on a posedge.
REQ-006 s_data  in  64  message word, big-endian; byte 0 is bits [63:56].
REQ-007 s_last / s_bytes  in / in  1 / 4  s_last marks the final word of the message; s_bytes is its valid-byte count (1..8); s_bytes is ignored when s_last=0.
REQ-008 s_mode  in  2  SHA-2 variant (0=224, 1=256, 2=384, 3=512); sampled on the first word of a message.
REQ-009 core_init_cmd / core_next_cmd  out / out  1 / 1  one-cycle command pulses to the hash core.
REQ-010 core_mode / core_block_msg  out / out  2 / 1024  latched mode and padded block; word i is bits [1023-64i -: 64].
REQ-011 core_ready  in  1  core idle/ready indication.
REQ-012 busy  out  1  high in any state other than FILL with word index 0 and no message in progress.

Function
- REQ-013 States: FILL, PAD, ISSUE, WAIT, EXTRA.
- REQ-014 s_ready=1 only in FILL; the accepted word is written to buffer word idx; idx increments 0..15.
- REQ-015 A non-last word accepted at idx=15 -> ISSUE.
- REQ-016 Each accepted word adds 64 bits to the bit-length counter; an s_last word adds 8*s_bytes. The counter wraps modulo 2^LEN_W.
- REQ-017 PAD (1 cycle, entered after an s_last word at index j with k bytes): if k<8, byte k of word j =0x80 and bytes k+1..7 =0; if k=8, the marker is placed at word j+1 byte 0 when j+1<=15.
- REQ-018 Let m be the word holding the marker. If m<=13, the length is written to words 14:15 and the block is final. Otherwise (m=14, m=15, or no room at j=15, k=8), an extra block is pending.
- REQ-019 ISSUE: hold until core_ready=1, then pulse core_init_cmd if this is the first block of the message, else core_next_cmd, for exactly one cycle; then go to WAIT.
- REQ-020 WAIT: the first WAIT cycle ignores core_ready; WAIT then exits on core_ready=1.
- REQ-021 WAIT exit: if an extra block is pending -> EXTRA; else if the block was final -> FILL with a new message; else -> FILL to continue the same message. The buffer is zeroed on exit in all three cases.
- REQ-022 EXTRA (1 cycle): word 0 =0x8000000000000000 only when the marker did not fit in the previous block; words 14:15 = length; all other words zero; then -> ISSUE, and the block is final.
- REQ-023 core_block_msg and core_mode SHALL be held stable from the command pulse until WAIT exits.
- REQ-024 Commands are never issued while core_ready=0; s_ready=0 in every state except FILL.
- REQ-025 zeroize has priority over all events: next cycle is FILL, idx=0, counter=0, buffer=0, command outputs 0, and the next message starts with init.
- REQ-026 Simultaneous s_valid and zeroize: the word is dropped.

Reset
- REQ-027 On reset_n=0: state FILL, idx=0, counter=0, buffer=0, core_mode=0.
- REQ-028 On reset_n=0: core_init_cmd=0, core_next_cmd=0, s_ready=0 while reset_n=0, s_ready=1 from the first cycle after release, busy=0.

Structure
- REQ-029 The state enum, the 0x80 marker constant, the mode encoding and the word/block widths SHALL live in the shared global package.
- REQ-030 One sub-module, sha512_pad_insert, SHALL hold the combinational marker/length insertion used by PAD and EXTRA.

Verification
- REQ-031 "abc": one word 0x6162630000000000, last, bytes=3, mode=3 -> one init pulse; word0=0x6162638000000000, words1-14=0, word15=0x18, core_mode=3.
- REQ-032 111 bytes (word13 last, bytes=7) -> one block; word13 byte7=0x80, word15=0x378, init only.
- REQ-033 112 bytes (word13 last, bytes=8) -> block1 via init with word14=0x8000000000000000, word15=0; block2 via next, all zero except word15=0x380.
- REQ-034 128 bytes -> block1 = data via init; block2 via next with word0=0x8000000000000000, word15=0x400.
- REQ-035 Core busy: core_ready held 0 for 90 cycles after the command -> no further pulses, s_ready=0, core_block_msg unchanged throughout.
- REQ-036 zeroize at idx=5 mid-message -> next cycle s_ready=1, idx=0; a following 1-byte message issues init with length 0x8.

Source files
------------

// File: rtl/sha512_msg_padder_pkg.sv
// Shared types and constants for the SHA-2 message padder: FSM states, mode
// encoding, block geometry and the padding marker byte.
package sha512_msg_padder_pkg;
    localparam int WORD_W      = 64;
    localparam int WORDS       = 16;
    localparam int BYTES_W     = WORD_W / 8;
    localparam int BLK_W       = WORD_W * WORDS;
    localparam int LEN_FIELD_W = 128;

    localparam logic [7:0] PAD_MARKER = 8'h80;

    typedef enum logic [1:0] {
        MODE_224 = 2'd0,
        MODE_256 = 2'd1,
        MODE_384 = 2'd2,
        MODE_512 = 2'd3
    } sha_mode_e;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_PAD,
        ST_ISSUE,
        ST_WAIT,
        ST_EXTRA
    } pad_state_e;

    // Word i lives at index WORDS-1-i and byte b at index BYTES_W-1-b, so the
    // flattened vector matches the big-endian core_block_msg layout.
    typedef logic [WORDS-1:0][BYTES_W-1:0][7:0] block_t;
endpackage

// File: rtl/sha512_msg_padder_if.sv
// Message-word stream into the padder: valid/ready handshake plus word,
// last flag, valid-byte count and SHA-2 variant.
interface sha512_msg_padder_if;
    import sha512_msg_padder_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic [3:0]        s_bytes;
    logic [1:0]        s_mode;

    modport master (output s_valid, s_data, s_last, s_bytes, s_mode, input s_ready);
    modport slave  (input s_valid, s_data, s_last, s_bytes, s_mode, output s_ready);
endinterface

// File: rtl/sha512_pad_insert.sv
// Combinational marker/length insertion into a 1024-bit block: writes 0x80 at
// the given word/byte, clears the rest of that word, and optionally the length.
module sha512_pad_insert
    import sha512_msg_padder_pkg::*;
(
    input  block_t                  blk_i,
    input  logic                    mk_en,
    input  logic [3:0]              mk_word,
    input  logic [2:0]              mk_byte,
    input  logic                    len_en,
    input  logic [LEN_FIELD_W-1:0]  len_field,
    output block_t                  blk_o
);
    always_comb begin
        blk_o = blk_i;
        if (mk_en) begin
            for (int b = 0; b < BYTES_W; b++) begin
                if (3'(b) == mk_byte)
                    blk_o[~mk_word][3'(BYTES_W - 1 - b)] = PAD_MARKER;
                else if (3'(b) > mk_byte)
                    blk_o[~mk_word][3'(BYTES_W - 1 - b)] = '0;
            end
        end
        // Words 14:15 are the two least-significant words of the block.
        if (len_en)
            blk_o[1:0] = len_field;
    end
endmodule

// File: rtl/sha512_msg_padder.sv
// SHA-384/512 message padder: fills a 16-word block from the input stream,
// appends the 0x80 marker and bit length, and hands blocks to the hash core.
module sha512_msg_padder
    import sha512_msg_padder_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              zeroize,
    sha512_msg_padder_if.slave s,
    output logic              core_init_cmd,
    output logic              core_next_cmd,
    output logic [1:0]        core_mode,
    output logic [BLK_W-1:0]  core_block_msg,
    input  logic              core_ready,
    output logic              busy
);
    pad_state_e       state_q, state_d;
    block_t           blk_q, ins_blk;
    logic [3:0]       idx_q, last_j_q, last_k_q;
    logic [LEN_W-1:0] len_q;
    sha_mode_e        mode_q;
    logic             in_msg_q, first_blk_q, extra_q, final_q, mk_done_q, wait_first_q;

    logic             pad_mk_en, pad_final, ins_mk_en, ins_len_en;
    logic [3:0]       pad_mk_word, ins_mk_word;
    logic [2:0]       pad_mk_byte, ins_mk_byte;
    logic [6:0]       len_add;
    logic             wait_exit;

    assign len_add   = s.s_last ? {s.s_bytes, 3'b000} : 7'd64;
    assign wait_exit = (state_q == ST_WAIT) && !wait_first_q && core_ready;

    // A full final word pushes the marker into the next word, if one exists.
    always_comb begin
        pad_mk_en   = 1'b1;
        pad_mk_word = last_j_q;
        pad_mk_byte = last_k_q[2:0];
        if (last_k_q[3]) begin
            pad_mk_word = last_j_q + 4'd1;
            pad_mk_byte = 3'd0;
            pad_mk_en   = (last_j_q != 4'd15);
        end
        pad_final = pad_mk_en && (pad_mk_word <= 4'd13);
    end

    always_comb begin
        ins_mk_en   = pad_mk_en;
        ins_mk_word = pad_mk_word;
        ins_mk_byte = pad_mk_byte;
        ins_len_en  = pad_final;
        if (state_q == ST_EXTRA) begin
            ins_mk_en   = !mk_done_q;
            ins_mk_word = 4'd0;
            ins_mk_byte = 3'd0;
            ins_len_en  = 1'b1;
        end
    end

    sha512_pad_insert u_insert (
        .blk_i     (blk_q),
        .mk_en     (ins_mk_en),
        .mk_word   (ins_mk_word),
        .mk_byte   (ins_mk_byte),
        .len_en    (ins_len_en),
        .len_field (LEN_FIELD_W'(len_q)),
        .blk_o     (ins_blk)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_FILL;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (s.s_valid) begin
                          if (s.s_last)            state_d = ST_PAD;
                          else if (idx_q == 4'd15) state_d = ST_ISSUE;
                      end
            ST_PAD:   state_d = ST_ISSUE;
            ST_ISSUE: if (core_ready) state_d = ST_WAIT;
            ST_WAIT:  if (wait_exit) state_d = extra_q ? ST_EXTRA : ST_FILL;
            ST_EXTRA: state_d = ST_ISSUE;
            default:  state_d = ST_FILL;
        endcase
        if (zeroize) state_d = ST_FILL;
    end

    always_comb begin
        s.s_ready     = reset_n && (state_q == ST_FILL);
        core_init_cmd = (state_q == ST_ISSUE) && core_ready && !zeroize && first_blk_q;
        core_next_cmd = (state_q == ST_ISSUE) && core_ready && !zeroize && !first_blk_q;
        busy          = !((state_q == ST_FILL) && (idx_q == 4'd0) && !in_msg_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_q <= '0; idx_q <= '0; len_q <= '0; mode_q <= MODE_224;
            last_j_q <= '0; last_k_q <= '0; in_msg_q <= 1'b0; first_blk_q <= 1'b1;
            extra_q <= 1'b0; final_q <= 1'b0; mk_done_q <= 1'b0; wait_first_q <= 1'b0;
        end else if (zeroize) begin
            blk_q <= '0; idx_q <= '0; len_q <= '0; mode_q <= MODE_224;
            last_j_q <= '0; last_k_q <= '0; in_msg_q <= 1'b0; first_blk_q <= 1'b1;
            extra_q <= 1'b0; final_q <= 1'b0; mk_done_q <= 1'b0; wait_first_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: if (s.s_valid) begin
                    blk_q[~idx_q] <= s.s_data;
                    len_q         <= len_q + LEN_W'(len_add);
                    idx_q         <= idx_q + 4'd1;
                    if (!in_msg_q) begin
                        mode_q   <= sha_mode_e'(s.s_mode);
                        in_msg_q <= 1'b1;
                    end
                    if (s.s_last) begin
                        last_j_q <= idx_q;
                        last_k_q <= s.s_bytes;
                    end
                end
                ST_PAD: begin
                    blk_q     <= ins_blk;
                    final_q   <= pad_final;
                    extra_q   <= !pad_final;
                    mk_done_q <= pad_mk_en;
                end
                ST_ISSUE: if (core_ready) begin
                    first_blk_q  <= 1'b0;
                    wait_first_q <= 1'b1;
                end
                ST_WAIT: begin
                    wait_first_q <= 1'b0;
                    if (wait_exit) begin
                        blk_q   <= '0;
                        idx_q   <= '0;
                        extra_q <= 1'b0;
                        if (!extra_q && final_q) begin
                            in_msg_q    <= 1'b0;
                            first_blk_q <= 1'b1;
                            len_q       <= '0;
                            final_q     <= 1'b0;
                        end
                    end
                end
                ST_EXTRA: begin
                    blk_q   <= ins_blk;
                    final_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign core_mode      = mode_q;
    assign core_block_msg = blk_q;
endmodule
